vga_palette_mux: RTL and testbench
==================================

Name: vga_palette_mux

Overview:
- Registered, palette-based successor to the fixed 8-colour RGB select mux in the VGA pixel path.
- Maps a SELECT_SIZE-bit colour index to a programmable RGB triple of OUT_RGB_SIZE bits per channel.
- Palette writes go through a valid/ready port and are deferred to blanking so no line tears; entries flagged as blinking are forced to black on alternate blink phases.
- Sits between the game/pixel generator and the DAC/VGA pins; delays the sync signals to match the pixel latency.

Parameters:
- SELECT_SIZE, 3, colour index width; palette depth = 2**SELECT_SIZE entries.
- OUT_RGB_SIZE, 8, bits per colour channel.
- DEFER_WRITES, 1, 1 = commit palette writes only while inActiveArea_i=0; 0 = commit on the cycle after acceptance.
- BLINK_FRAMES, 30, vsync rising edges per blink phase (must be >=1).

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  synchronous reset, active-high
- select_i  in  SELECT_SIZE  colour index for the current pixel
- inActiveArea_i  in  1  current pixel is in the visible area
- hsync_i  in  1  horizontal sync, aligned with select_i
- vsync_i  in  1  vertical sync, aligned with select_i (active-high pulse)
- pal_wr_valid_i  in  1  palette write request
- pal_wr_ready_o  out  1  holding register empty, write can be accepted
- pal_wr_addr_i  in  SELECT_SIZE  palette entry to write
- pal_wr_data_i  in  3*OUT_RGB_SIZE  {red, green, blue}
- pal_wr_blink_i  in  1  blink-enable flag for the entry
- red_o, green_o, blue_o  out  OUT_RGB_SIZE each  pixel colour
- hsync_o, vsync_o  out  1  syncs delayed to match the colour outputs
- active_o  out  1  inActiveArea_i delayed to match the colour outputs

Behaviour:
- Reset (rst_i high at a rising clk_i) produces:
  - all colour outputs 0; hsync_o, vsync_o and active_o 0; pipeline valid bits cleared.
  - holding register empty, so pal_wr_ready_o=1; blink phase 0; frame counter 0; all blink flags 0.
  - each palette entry i reloaded with the default colour, using the low 3 bits of i: bit2 → red all-ones, bit1 → green all-ones, bit0 → blue all-ones, otherwise 0. Index 0 is black, 7 white, 4 red, 2 green, 1 blue, and the pattern repeats every 8 entries.
- Reset applies mid-write: a pending held write is discarded.
- Pixel pipeline, fixed 2-cycle latency:
  - Stage 1 registers select_i, inActiveArea_i, hsync_i and vsync_i.
  - Stage 2 looks up the palette with the stage-1 index and registers the outputs.
  - Outputs are 0 whenever the stage-1 active flag is 0.
  - Outputs are black when the entry's blink flag is 1 and the blink phase is 1.
  - hsync_o, vsync_o and active_o equal their inputs delayed by exactly 2 cycles.
- Write handshake:
  - A write is accepted on a cycle where pal_wr_valid_i and pal_wr_ready_o are both 1; address, data and blink are captured into the holding register and ready drops the next cycle.
  - With DEFER_WRITES=1, the held write commits at the first rising edge where the holding register is full and inActiveArea_i=0.
  - With DEFER_WRITES=0, the held write commits at the rising edge following acceptance.
  - pal_wr_ready_o returns to 1 on the cycle after commit. There is no accept in the commit cycle, so maximum throughput is one write per 2 cycles.
  - valid held while ready=0 is ignored and must stay asserted; data may change only after acceptance.
- Read/write collision: a lookup in the same cycle as a commit to the same entry returns the old value; the new value is visible from the next lookup.
- Blink:
  - A rising edge of vsync_i (current 1, previous sample 0) increments the frame counter.
  - When the counter reaches BLINK_FRAMES-1 and another rising edge arrives, the counter wraps to 0 and the blink phase toggles.
  - A vsync_i held high counts once.
- Widths: there is no arithmetic on colour data. The frame counter is clog2(BLINK_FRAMES+1) bits wide.

Test Plan:
- Reset, then drive indices 0,7,4,2,1 with inActiveArea_i=1 → two cycles later RGB = 000000, FFFFFF, FF0000, 00FF00, 0000FF respectively. Index 3 → 00FFFF.
- inActiveArea_i=0 with select_i=7, hsync_i pulse → RGB 0; hsync_o and active_o each equal their input delayed by exactly 2 cycles.
- DEFER_WRITES=1: write addr 7 data 123456 while active stays 1 for 20 cycles → ready=0 and index-7 pixels remain FFFFFF. Drop inActiveArea_i → commit, ready=1 next cycle, following active index-7 pixels output 12/34/56.
- Back-to-back valid writes to addr 1 then 2 → accepts separated by at least 2 cycles, both values read back correctly; second request held until ready returns.
- BLINK_FRAMES=2, write addr 4 with blink=1, issue 4 vsync pulses → index 4 reads FF0000 before pulse 2, black after pulse 2, FF0000 after pulse 4; index 2 is unaffected throughout.
- Accept a write, assert rst_i before it commits → the entry keeps its default colour, ready=1, and blink phase and counter are 0.

Source files
------------

// File: rtl/vga_palette_mux.sv
// Registered palette lookup for the VGA pixel path: 2-cycle colour pipeline with matched syncs,
// a valid/ready palette write port that can defer commits to blanking, and per-entry blinking.
module vga_palette_mux #(
  parameter int unsigned SELECT_SIZE  = 3,
  parameter int unsigned OUT_RGB_SIZE = 8,
  parameter bit          DEFER_WRITES = 1'b1,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [SELECT_SIZE-1:0]    select_i,
  input  logic                      inActiveArea_i,
  input  logic                      hsync_i,
  input  logic                      vsync_i,
  input  logic                      pal_wr_valid_i,
  output logic                      pal_wr_ready_o,
  input  logic [SELECT_SIZE-1:0]    pal_wr_addr_i,
  input  logic [3*OUT_RGB_SIZE-1:0] pal_wr_data_i,
  input  logic                      pal_wr_blink_i,
  output logic [OUT_RGB_SIZE-1:0]   red_o,
  output logic [OUT_RGB_SIZE-1:0]   green_o,
  output logic [OUT_RGB_SIZE-1:0]   blue_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      active_o
);

  localparam int unsigned Depth = 2 ** SELECT_SIZE;
  localparam int unsigned DataW = 3 * OUT_RGB_SIZE;
  localparam int unsigned CntW  = $clog2(BLINK_FRAMES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

  // Low three index bits select which channels are saturated (0 black, 7 white, 4 red, ...).
  function automatic logic [DataW-1:0] default_colour(input int unsigned idx);
    logic [2:0] b;
    b = idx[2:0];
    return {{OUT_RGB_SIZE{b[2]}}, {OUT_RGB_SIZE{b[1]}}, {OUT_RGB_SIZE{b[0]}}};
  endfunction

  logic [DataW-1:0]       palette_q [Depth];
  logic [Depth-1:0]       blink_q;

  logic                   hold_full_q;
  logic [SELECT_SIZE-1:0] hold_addr_q;
  logic [DataW-1:0]       hold_data_q;
  logic                   hold_blink_q;
  logic                   accept;
  logic                   commit;

  logic [SELECT_SIZE-1:0] sel_q;
  logic                   act_q;
  logic                   hs_q;
  logic                   vs_q;

  logic [CntW-1:0]        frame_cnt_q;
  logic                   phase_q;
  logic                   vs_rise;

  logic [DataW-1:0]       pix_d;
  logic [DataW-1:0]       pix_q;
  logic                   hs_out_q;
  logic                   vs_out_q;
  logic                   act_out_q;

  assign pal_wr_ready_o = !hold_full_q;
  assign accept         = pal_wr_valid_i && !hold_full_q;
  assign commit         = hold_full_q && (!DEFER_WRITES || !inActiveArea_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_full_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      hold_blink_q <= 1'b0;
    end else if (accept) begin
      hold_full_q  <= 1'b1;
      hold_addr_q  <= pal_wr_addr_i;
      hold_data_q  <= pal_wr_data_i;
      hold_blink_q <= pal_wr_blink_i;
    end else if (commit) begin
      hold_full_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        palette_q[i] <= default_colour(i);
      end
      blink_q <= '0;
    end else if (commit) begin
      palette_q[hold_addr_q] <= hold_data_q;
      blink_q[hold_addr_q]   <= hold_blink_q;
    end
  end

  // vs_q holds the previous vsync_i sample, so it doubles as the edge detector.
  assign vs_rise = vsync_i && !vs_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (vs_rise) begin
      if (frame_cnt_q == CntLast) begin
        frame_cnt_q <= '0;
        phase_q     <= !phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sel_q <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else begin
      sel_q <= select_i;
      act_q <= inActiveArea_i;
      hs_q  <= hsync_i;
      vs_q  <= vsync_i;
    end
  end

  // A commit in this cycle lands after the lookup, so a same-entry read sees the old colour.
  always_comb begin
    pix_d = palette_q[sel_q];
    if (!act_q || (blink_q[sel_q] && phase_q)) begin
      pix_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pix_q     <= '0;
      hs_out_q  <= 1'b0;
      vs_out_q  <= 1'b0;
      act_out_q <= 1'b0;
    end else begin
      pix_q     <= pix_d;
      hs_out_q  <= hs_q;
      vs_out_q  <= vs_q;
      act_out_q <= act_q;
    end
  end

  assign red_o    = pix_q[DataW-1 -: OUT_RGB_SIZE];
  assign green_o  = pix_q[2*OUT_RGB_SIZE-1 -: OUT_RGB_SIZE];
  assign blue_o   = pix_q[OUT_RGB_SIZE-1:0];
  assign hsync_o  = hs_out_q;
  assign vsync_o  = vs_out_q;
  assign active_o = act_out_q;

endmodule

// File: tb/tb_vga_palette_mux.sv
// Directed bench for vga_palette_mux: default palette table, sync alignment, deferred writes,
// write throughput, blinking and reset during a held write.
module tb_vga_palette_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        act;
  logic        hs;
  logic        vs;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_blink;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        hs_out;
  logic        vs_out;
  logic        act_out;
  logic [23:0] rgb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  assign rgb = {red, green, blue};

  vga_palette_mux #(
    .SELECT_SIZE (3),
    .OUT_RGB_SIZE(8),
    .DEFER_WRITES(1'b1),
    .BLINK_FRAMES(2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .select_i      (sel),
    .inActiveArea_i(act),
    .hsync_i       (hs),
    .vsync_i       (vs),
    .pal_wr_valid_i(wr_valid),
    .pal_wr_ready_o(wr_ready),
    .pal_wr_addr_i (wr_addr),
    .pal_wr_data_i (wr_data),
    .pal_wr_blink_i(wr_blink),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue),
    .hsync_o       (hs_out),
    .vsync_o       (vs_out),
    .active_o      (act_out)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [23:0] exp;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [23:0] actual, input logic [23:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drive one active index and return after its colour reaches the outputs.
  task automatic look(input logic [2:0] s);
    sel = s;
    act = 1'b1;
    step();
    step();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [23:0] d, input logic b,
                          output int acc_cyc);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_blink = b;
    n = 0;
    while (!wr_ready && n < 50) begin
      step();
      n++;
    end
    check("wr_ready_timeout", {23'b0, wr_ready}, 24'd1);
    acc_cyc = cyc + 1;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic vs_pulse(input int len);
    vs = 1'b1;
    repeat (len) step();
    vs = 1'b0;
    step();
  endtask

  vec_t vecs [6];
  int   acc1, acc2;

  initial begin
    vecs[0] = '{sel: 3'd0, exp: 24'h000000};
    vecs[1] = '{sel: 3'd7, exp: 24'hFFFFFF};
    vecs[2] = '{sel: 3'd4, exp: 24'hFF0000};
    vecs[3] = '{sel: 3'd2, exp: 24'h00FF00};
    vecs[4] = '{sel: 3'd1, exp: 24'h0000FF};
    vecs[5] = '{sel: 3'd3, exp: 24'h00FFFF};

    rst = 1'b0; sel = '0; act = 1'b0; hs = 1'b0; vs = 1'b0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_blink = 1'b0;
    do_reset();

    check("reset_rgb", rgb, 24'h0);
    check("reset_syncs", {21'b0, hs_out, vs_out, act_out}, 24'h0);
    check("reset_ready", {23'b0, wr_ready}, 24'd1);

    for (int i = 0; i < 6; i++) begin
      look(vecs[i].sel);
      check($sformatf("default_idx%0d", vecs[i].sel), rgb, vecs[i].exp);
    end

    // Sync and active alignment: inactive white index must stay black.
    act = 1'b0; sel = 3'd7; hs = 1'b0;
    step(); step();
    hs = 1'b1;
    step();
    check("hsync_not_1cyc", {23'b0, hs_out}, 24'd0);
    hs = 1'b0; act = 1'b1;
    step();
    check("hsync_2cyc", {23'b0, hs_out}, 24'd1);
    check("inactive_rgb", rgb, 24'h0);
    check("active_still_0", {23'b0, act_out}, 24'd0);
    act = 1'b0;
    step();
    check("hsync_fall", {23'b0, hs_out}, 24'd0);
    check("active_2cyc", {23'b0, act_out}, 24'd1);
    check("active_rgb", rgb, 24'hFFFFFF);
    step();
    check("active_fall", {23'b0, act_out}, 24'd0);

    do_reset();

    // Deferred write: held while active, commits at first blanking cycle.
    act = 1'b1; sel = 3'd7;
    do_write(3'd7, 24'h123456, 1'b0, acc1);
    check("defer_ready_low", {23'b0, wr_ready}, 24'd0);
    repeat (20) step();
    check("defer_ready_still_low", {23'b0, wr_ready}, 24'd0);
    check("defer_old_colour", rgb, 24'hFFFFFF);
    act = 1'b0;
    step();
    check("collision_old_value", rgb, 24'hFFFFFF);
    check("ready_after_commit", {23'b0, wr_ready}, 24'd1);
    look(3'd7);
    check("defer_new_colour", rgb, 24'h123456);
    act = 1'b0;

    // Back-to-back requests: second valid stays up until ready returns.
    do_write(3'd1, 24'hAABBCC, 1'b0, acc1);
    check("b2b_ready_low", {23'b0, wr_ready}, 24'd0);
    do_write(3'd2, 24'hDDEEFF, 1'b0, acc2);
    check("b2b_spacing_ge2", {23'b0, (acc2 - acc1) >= 2}, 24'd1);
    act = 1'b0;
    step();
    look(3'd1);
    check("b2b_read1", rgb, 24'hAABBCC);
    look(3'd2);
    check("b2b_read2", rgb, 24'hDDEEFF);
    act = 1'b0;

    // Blink with two frames per phase; third pulse held high to count only once.
    do_write(3'd4, 24'hFF0000, 1'b1, acc1);
    step();
    look(3'd4);
    check("blink_p0", rgb, 24'hFF0000);
    act = 1'b0;
    vs = 1'b1;
    step();
    step();
    check("vsync_2cyc", {23'b0, vs_out}, 24'd1);
    vs = 1'b0;
    step();
    look(3'd4);
    check("blink_p1", rgb, 24'hFF0000);
    act = 1'b0;
    vs_pulse(1);
    look(3'd4);
    check("blink_p2_black", rgb, 24'h0);
    look(3'd2);
    check("blink_idx2_p2", rgb, 24'hDDEEFF);
    act = 1'b0;
    vs_pulse(4);
    look(3'd4);
    check("blink_p3_black", rgb, 24'h0);
    act = 1'b0;
    vs_pulse(1);
    look(3'd4);
    check("blink_p4_red", rgb, 24'hFF0000);
    look(3'd2);
    check("blink_idx2_p4", rgb, 24'hDDEEFF);
    act = 1'b0;

    // Leave phase 1, counter 1, then reset over a held write.
    vs_pulse(1); vs_pulse(1); vs_pulse(1);
    look(3'd4);
    check("pre_reset_black", rgb, 24'h0);
    do_write(3'd5, 24'h111111, 1'b1, acc1);
    check("held_ready_low", {23'b0, wr_ready}, 24'd0);
    rst = 1'b1;
    act = 1'b0;
    step();
    rst = 1'b0;
    check("rst_ready", {23'b0, wr_ready}, 24'd1);
    step(); step();
    look(3'd5);
    check("rst_idx5_default", rgb, 24'hFF00FF);
    look(3'd4);
    check("rst_idx4_default", rgb, 24'hFF0000);
    look(3'd7);
    check("rst_idx7_default", rgb, 24'hFFFFFF);
    act = 1'b0;
    do_write(3'd4, 24'hFF0000, 1'b1, acc1);
    step();
    vs_pulse(1);
    look(3'd4);
    check("rst_cnt_zero", rgb, 24'hFF0000);
    act = 1'b0;
    vs_pulse(1);
    look(3'd4);
    check("rst_phase_toggle", rgb, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
